// File: rtl/log2_frac_iter.sv
// log2_frac_iter: iterative bfloat16 log2 producing {unbiased exponent, FRAC_BITS fraction bits}
// via a square-and-compare recurrence on the normalised mantissa, one bit per cycle.
module log2_frac_iter #(
    parameter int FRAC_BITS = 8,
    parameter int EXP_BIAS  = 127
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [7:0]             exp_in,
    input  logic [6:0]             frac_in,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [8+FRAC_BITS-1:0] log_out,
    output logic                   flag_zero,
    output logic                   flag_nan
);
    typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;
    state_t state, state_nx;
    logic [7:0] m, m_nx, int_part;
    logic [15:0] p;
    logic [FRAC_BITS-1:0] frac, frac_sh;
    logic [4:0] cnt;
    logic special, last;
    assign p = 16'(m) * 16'(m);
    assign m_nx = p[15] ? p[15:8] : p[14:7];
    assign frac_sh = FRAC_BITS'({frac, p[15]});
    assign last = cnt == 5'(FRAC_BITS - 1);
    assign special = exp_in == 8'h00 || exp_in == 8'hFF;
    assign in_ready = state == IDLE && !rst;
    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else state <= state_nx;
    end
    always_comb begin
        state_nx = state;
        state_nx = (state == IDLE && in_valid) ? (special ? DONE : CALC) :
                   (state == CALC && last) ? DONE :
                   (state == DONE && out_valid && out_ready) ? IDLE : state;
    end
    // Specials enter DONE at once; out_valid is raised one edge later from DONE itself.
    always_ff @(posedge clk) begin
        if (rst) begin
            m         <= '0;
            int_part  <= '0;
            frac      <= '0;
            cnt       <= '0;
            log_out   <= '0;
            out_valid <= 1'b0;
            flag_zero <= 1'b0;
            flag_nan  <= 1'b0;
        end else begin
            case (state)
                IDLE: if (in_valid) begin
                    int_part  <= exp_in - 8'(EXP_BIAS);
                    m         <= {1'b1, frac_in};
                    frac      <= '0;
                    cnt       <= '0;
                    log_out   <= '0;
                    flag_zero <= exp_in == 8'h00;
                    flag_nan  <= exp_in == 8'hFF;
                end
                CALC: begin
                    m    <= m_nx;
                    frac <= frac_sh;
                    cnt  <= cnt + 5'd1;
                    if (last) begin
                        log_out   <= {int_part, frac_sh};
                        out_valid <= 1'b1;
                    end
                end
                DONE: out_valid <= !(out_valid && out_ready);
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_log2_frac_iter.sv
// tb_log2_frac_iter: directed checks of log2_frac_iter results, latency, flags,
// backpressure and mid-operation reset against hand-computed values.
module tb_log2_frac_iter;
    logic clk = 1'b0, rst = 1'b1, in_valid = 1'b0, out_ready = 1'b1;
    logic [7:0] exp_in = '0;
    logic [6:0] frac_in = '0;
    logic in_ready, out_valid, flag_zero, flag_nan;
    logic [15:0] log_out;
    int errors = 0, checks = 0;

    log2_frac_iter dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .exp_in(exp_in), .frac_in(frac_in), .out_valid(out_valid),
        .out_ready(out_ready), .log_out(log_out), .flag_zero(flag_zero),
        .flag_nan(flag_nan)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Present one operand, wait (bounded) for out_valid, check latency and result.
    task automatic op(input string tag, input logic [7:0] e, input logic [6:0] f,
                      input logic [15:0] exp_log, input int exp_lat,
                      input logic zf, input logic nf);
        int n;
        exp_in = e;
        frac_in = f;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        chk({tag, "_busy"}, in_ready, 0);
        n = 0;
        while (!out_valid && n < 40) begin
            tick();
            n++;
        end
        chk({tag, "_lat"}, n, exp_lat);
        chk({tag, "_log"}, log_out, exp_log);
        chk({tag, "_fz"}, flag_zero, zf);
        chk({tag, "_fn"}, flag_nan, nf);
    endtask

    task automatic consume(input string tag);
        out_ready = 1'b1;
        tick();
        chk({tag, "_vld0"}, out_valid, 0);
        chk({tag, "_rdy1"}, in_ready, 1);
    endtask

    initial begin
        tick();
        tick();
        chk("rst_rdy", in_ready, 0);
        chk("rst_vld", out_valid, 0);
        chk("rst_log", log_out, 0);
        chk("rst_flags", {flag_zero, flag_nan}, 0);
        rst = 1'b0;
        tick();
        chk("post_rst_rdy", in_ready, 1);

        op("x1p0", 8'd127, 7'h00, 16'h0000, 8, 0, 0);
        consume("x1p0");
        op("x1p5", 8'd127, 7'h40, 16'h0095, 8, 0, 0);
        consume("x1p5");
        op("x3p0", 8'd128, 7'h40, 16'h0195, 8, 0, 0);
        consume("x3p0");
        op("x0p75", 8'd126, 7'h40, 16'hFF95, 8, 0, 0);
        consume("x0p75");
        op("zero", 8'd0, 7'h11, 16'h0000, 1, 1, 0);
        consume("zero");
        op("nan", 8'd255, 7'h00, 16'h0000, 1, 0, 1);
        consume("nan");
        op("flags_clr", 8'd128, 7'h40, 16'h0195, 8, 0, 0);
        consume("flags_clr");

        out_ready = 1'b0;
        op("bp", 8'd127, 7'h40, 16'h0095, 8, 0, 0);
        for (int i = 0; i < 5; i++) begin
            exp_in = 8'd0;
            in_valid = (i % 2) == 0;
            tick();
            chk("bp_vld", out_valid, 1);
            chk("bp_log", log_out, 16'h0095);
            chk("bp_rdy", in_ready, 0);
        end
        in_valid = 1'b0;
        consume("bp");
        tick();
        chk("bp_idle", in_ready, 1);
        chk("bp_dropped", out_valid, 0);

        exp_in = 8'd127;
        frac_in = 7'h40;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        tick();
        tick();
        tick();
        rst = 1'b1;
        tick();
        chk("abort_vld", out_valid, 0);
        chk("abort_log", log_out, 0);
        chk("abort_rdy", in_ready, 0);
        rst = 1'b0;
        tick();
        chk("abort_rdy1", in_ready, 1);
        for (int i = 0; i < 10; i++) begin
            tick();
            chk("abort_no_out", out_valid, 0);
        end
        op("fresh", 8'd127, 7'h40, 16'h0095, 8, 0, 0);
        consume("fresh");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
